sipo_word_deserializer: RTL
===========================

// Module: sipo_word_deserializer
// PURPOSE
//  Downstream consumer of the d_ff bit stage: samples a registered serial bit
//  stream (q) and assembles it into WIDTH-bit parallel words.
//  Completed words sit in a 1-entry output buffer behind a valid/ready handshake.
//  Words that arrive while the buffer is still full are dropped and flagged.
//  Feeds word-level logic (pattern match, register file write) in the same clock domain.
// PARAMETERS
//  WIDTH      8   bits per assembled word (>=2)
//  MSB_FIRST  1   1: first received bit lands in word_out[WIDTH-1]; 0: lands in word_out[0]
// PORTS
//  clk         in   1              system clock, rising-edge
//  reset       in   1              asynchronous, active-high; clears all state
//  bit_in      in   1              serial data bit (driven from d_ff q)
//  bit_valid   in   1              bit_in sampled on this edge when high
//  clear       in   1              synchronous flush of partial word, buffer and overflow
//  word_out    out  WIDTH          assembled word; stable while word_valid=1
//  word_valid  out  1              output buffer holds a word
//  word_ready  in   1              consumer accepts word_out this cycle
//  bit_count   out  $clog2(WIDTH)  bits collected in the current partial word
//  overflow    out  1              sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (async, any time, incl. mid-word): shift reg=0, bit_count=0,
//   word_out=0, word_valid=0, overflow=0; state=EMPTY.
//  Collection: each edge with bit_valid=1 shifts bit_in into shift reg:
//   MSB_FIRST=1 -> sr <= {sr[WIDTH-2:0],bit_in}; MSB_FIRST=0 -> sr <= {bit_in,sr[WIDTH-1:1]}.
//   bit_count increments 0..WIDTH-1. The WIDTH-th bit completes the word:
//   bit_count wraps to 0, no idle cycle needed; next bit starts the next word.
//  Latency: word_valid rises on the edge that samples the last bit
//   (visible the following cycle); word_out = full word incl. that bit.
//  Output buffer FSM (2 states):
//   EMPTY: word_valid=0. Completion -> load word_out, go FULL.
//   FULL : word_valid=1. word_ready=1 & no completion -> EMPTY.
//          word_ready=1 & completion same edge -> load new word, stay FULL (no drop).
//          word_ready=0 & completion -> new word discarded, word_out unchanged,
//          overflow<=1, stay FULL.
//  word_ready is ignored while EMPTY.
//  overflow is sticky; cleared only by reset or clear.
//  clear=1: next edge bit_count=0, sr=0, word_valid=0, overflow=0, state=EMPTY;
//   clear beats bit_valid and word_ready on the same edge (sampled bit is dropped).
//  bit_valid=0: all state holds; gaps between bits of any length allowed.
//  All outputs are registered; no combinational in->out paths.
// STRUCTURE
//  Shared package sipo_pkg: state encodings ST_EMPTY=1'b0, ST_FULL=1'b1;
//   default WIDTH constant; count-width function CNT_W(WIDTH)=$clog2(WIDTH).
//  Top: shift register + bit counter + completion strobe.
//  Sub-module sipo_out_buf: 1-entry buffer FSM owning word_out, word_valid,
//   overflow; inputs load_word, load_strobe, word_ready, clear.
// TESTING  (WIDTH=8 unless noted; drive inputs on negedge clk)
//  1. reset pulse, then bits 1,0,1,0,0,1,0,1 back-to-back, word_ready=1 ->
//     word_valid=1 for one cycle after 8th bit, word_out=8'hA5, bit_count 0..7 then 0.
//  2. MSB_FIRST=0, same bits -> word_out=8'hA5 bit-reversed = 8'hA5 (palindrome);
//     repeat with 1,1,0,0,0,0,0,0 -> word_out=8'h03.
//  3. word_ready=0, send 16'hA53C as two words -> word_out stays 8'hA5,
//     overflow=1 after 16th bit; then word_ready=1 -> word_valid drops, overflow stays 1.
//  4. word held FULL, word_ready=1 on same edge as next word's 8th bit ->
//     word_out updates to new word, word_valid stays 1, overflow=0.
//  5. assert reset asynchronously (mid-cycle) after 5 bits -> bit_count=0,
//     word_valid=0 immediately; next 8 bits 8'hFF -> word_out=8'hFF.
//  6. clear with bit_valid=1 after 3 bits, overflow=1 -> bit_count=0, overflow=0,
//     that bit ignored; bits 8'h5A then produce word_out=8'h5A.

Source files
------------

// File: rtl/sipo_word_deserializer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : sipo_pkg                                                          |
// | Desc   : Shared types, constants and helpers for the SIPO word deserializer|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sipo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

  function automatic int CNT_W(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_word_deserializer_if.sv
// +----------------------------------------------------------------------------+
// | Module : sipo_word_deserializer_if                                         |
// | Desc   : Serial input side and word valid/ready side of the deserializer   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sipo_word_deserializer_if #(
  parameter int WIDTH = sipo_pkg::DEFAULT_WIDTH
);
  import sipo_pkg::*;

  logic                      bit_in;
  logic                      bit_valid;
  logic                      clear;
  logic                      word_ready;
  logic [WIDTH-1:0]          word_out;
  logic                      word_valid;
  logic [CNT_W(WIDTH)-1:0]   bit_count;
  logic                      overflow;

  modport master (
    output bit_in, bit_valid, clear, word_ready,
    input  word_out, word_valid, bit_count, overflow
  );

  modport slave (
    input  bit_in, bit_valid, clear, word_ready,
    output word_out, word_valid, bit_count, overflow
  );

endinterface

`default_nettype wire

// File: rtl/sipo_word_deserializer_out_buf.sv
// +----------------------------------------------------------------------------+
// | Module : sipo_out_buf                                                      |
// | Desc   : 1-entry output word buffer with valid/ready and sticky overflow   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_word,
  input  logic             load_strobe,
  input  logic             word_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overflow
);

  buf_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_word,  w_word_nxt;
  logic             r_ovf,   w_ovf_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_word  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_ovf_nxt   = r_ovf;
    if (clear) begin
      w_state_nxt = ST_EMPTY;
      w_ovf_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (load_strobe) begin
            w_word_nxt  = load_word;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          // A word completing while the consumer drains replaces it in place.
          if (load_strobe) begin
            if (word_ready) w_word_nxt = load_word;
            else            w_ovf_nxt  = 1'b1;
          end else if (word_ready) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign word_out   = r_word;
  assign word_valid = (r_state == ST_FULL);
  assign overflow   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/sipo_word_deserializer.sv
// +----------------------------------------------------------------------------+
// | Module : sipo_word_deserializer                                            |
// | Desc   : Assembles a serial bit stream into WIDTH-bit words                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sipo_word_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  sipo_word_deserializer_if.slave  bus
);

  localparam int            CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [CW-1:0]    r_cnt;
  logic             w_take;
  logic             w_done;

  assign w_take = bus.bit_valid & ~bus.clear;
  assign w_done = w_take && (r_cnt == LAST);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sr_nxt = {r_sr[WIDTH-2:0], bus.bit_in};
    end else begin : g_lsb_first
      assign w_sr_nxt = {bus.bit_in, r_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (bus.clear) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (bus.bit_valid) begin
      r_sr  <= w_sr_nxt;
      r_cnt <= w_done ? '0 : r_cnt + 1'b1;
    end
  end

  assign bus.bit_count = r_cnt;

  // The completed word is the shifted value, so the last bit is included.
  sipo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .reset       (reset),
    .load_word   (w_sr_nxt),
    .load_strobe (w_done),
    .word_ready  (bus.word_ready),
    .clear       (bus.clear),
    .word_out    (bus.word_out),
    .word_valid  (bus.word_valid),
    .overflow    (bus.overflow)
  );

endmodule

`default_nettype wire
